// File: rtl/modulo_updown_counter.sv
// Modulo-N up/down counter with wrap, saturate or one-shot end behaviour.
// Ports: clk, reset (sync, high), enable, up, load, load_val, clr_ovf in;
//        q (count), tc (terminal pulse), ovf (sticky), done (one-shot) out.
module modulo_updown_counter #(
   parameter int unsigned     WIDTH   = 8,
   parameter longint unsigned MODULUS = 256,
   parameter int unsigned     MODE    = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf,
   output logic             done
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_C = (WIDTH + 1)'(MODULUS);

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] DONE = 1'b1;

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic [0:0]       st_q, st_d;

   logic             live;
   logic             term;
   logic [WIDTH-1:0] ld_clamp;
   logic [WIDTH-1:0] step;

   always_comb begin
      // only the one-shot mode ever leaves RUN
      live     = (MODE != 2) || (st_q == RUN);
      term     = enable && live &&
                 (up ? (cnt_q == MAX_C) : (cnt_q == '0));
      ld_clamp = ({1'b0, load_val} >= MOD_C) ? MAX_C : load_val;
      step     = up ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);

      cnt_d = cnt_q;
      st_d  = st_q;
      tc_d  = 1'b0;
      ovf_d = clr_ovf ? 1'b0 : ovf_q;

      if (load) begin
         cnt_d = ld_clamp;
         st_d  = RUN;
      end else if (term) begin
         tc_d  = 1'b1;
         // setting beats a same-cycle clr_ovf
         ovf_d = 1'b1;
         if (MODE == 0) begin
            cnt_d = up ? '0 : MAX_C;
         end
         if (MODE == 2) begin
            st_d = DONE;
         end
      end else if (enable && live) begin
         cnt_d = step;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
         st_q  <= RUN;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
         st_q  <= st_d;
      end
   end

   assign q    = cnt_q;
   assign tc   = tc_q;
   assign ovf  = ovf_q;
   assign done = (MODE == 2) && (st_q == DONE);

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Directed bench for modulo_updown_counter in four configurations:
// default wrap, mod-10 wrap, mod-10 saturate, mod-10 one-shot.
module tb_modulo_updown_counter;

   logic       clk = 1'b0;
   logic       reset, enable, up, load, clr_ovf;
   logic [7:0] load_val;
   logic [7:0] qa [4];
   logic       tca [4];
   logic       ovfa [4];
   logic       donea [4];

   int npass = 0;
   int ntot  = 0;

   always #5 clk = ~clk;

   modulo_updown_counter #(.WIDTH(8), .MODULUS(256), .MODE(0)) u0 (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf),
      .q(qa[0]), .tc(tca[0]), .ovf(ovfa[0]), .done(donea[0]));

   modulo_updown_counter #(.WIDTH(8), .MODULUS(10), .MODE(0)) u1 (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf),
      .q(qa[1]), .tc(tca[1]), .ovf(ovfa[1]), .done(donea[1]));

   modulo_updown_counter #(.WIDTH(8), .MODULUS(10), .MODE(1)) u2 (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf),
      .q(qa[2]), .tc(tca[2]), .ovf(ovfa[2]), .done(donea[2]));

   modulo_updown_counter #(.WIDTH(8), .MODULUS(10), .MODE(2)) u3 (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf),
      .q(qa[3]), .tc(tca[3]), .ovf(ovfa[3]), .done(donea[3]));

   typedef struct {
      int         sel;
      logic       rst, ld;
      logic [7:0] lv;
      logic       en, up, clr;
      int         q;
      logic       tc, ovf, done;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(int sel, logic rst, logic ld, int lv,
                               logic en, logic u, logic clr, int q,
                               logic tc, logic ovf, logic dn);
      vec_t v;
      v.sel  = sel;
      v.rst  = rst;
      v.ld   = ld;
      v.lv   = 8'(lv);
      v.en   = en;
      v.up   = u;
      v.clr  = clr;
      v.q    = q;
      v.tc   = tc;
      v.ovf  = ovf;
      v.done = dn;
      return v;
   endfunction

   task automatic chk(string nm, int act, int exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic tick(logic rst, logic ld, int lv, logic en,
                       logic u, logic clr);
      reset    = rst;
      load     = ld;
      load_val = 8'(lv);
      enable   = en;
      up       = u;
      clr_ovf  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(string nm, int s, int q, logic tc,
                          logic ovf, logic dn);
      chk({nm, ".q"},    int'(qa[s]),    q);
      chk({nm, ".tc"},   int'(tca[s]),   int'(tc));
      chk({nm, ".ovf"},  int'(ovfa[s]),  int'(ovf));
      chk({nm, ".done"}, int'(donea[s]), int'(dn));
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; load_val = '0;
      enable = 1'b0; up = 1'b0; clr_ovf = 1'b0;

      // default config: full 256-step wrap
      tick(1, 0, 0, 1, 1, 0);
      chk_all("d0.rst", 0, 0, 0, 0, 0);
      for (int k = 1; k <= 256; k++) begin
         tick(0, 0, 0, 1, 1, 0);
         chk($sformatf("d0.run%0d.q", k), int'(qa[0]), k % 256);
         chk($sformatf("d0.run%0d.tc", k), int'(tca[0]),
             (k == 256) ? 1 : 0);
         chk($sformatf("d0.run%0d.ovf", k), int'(ovfa[0]),
             (k == 256) ? 1 : 0);
      end
      // load beats enable, ovf untouched
      tick(0, 1, 200, 1, 1, 0);
      chk_all("d0.ld200", 0, 200, 0, 1, 0);
      // reset beats load
      tick(1, 1, 100, 1, 1, 0);
      chk_all("d0.rstld", 0, 0, 0, 0, 0);
      tick(0, 1, 255, 0, 1, 0);
      chk_all("d0.ld255", 0, 255, 0, 0, 0);
      // set wins over clear
      tick(0, 0, 0, 1, 1, 1);
      chk_all("d0.setclr", 0, 0, 1, 1, 0);
      tick(0, 0, 0, 0, 1, 1);
      chk_all("d0.clr", 0, 0, 0, 0, 0);

      // sel rst ld lv en up clr | q tc ovf done
      tv.push_back(mk(1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 0, 0,  0, 1, 0, 0, 9, 1, 1, 0));
      tv.push_back(mk(1, 0, 0,  0, 1, 0, 0, 8, 0, 1, 0));
      tv.push_back(mk(1, 0, 0,  0, 1, 0, 0, 7, 0, 1, 0));
      tv.push_back(mk(1, 0, 1, 15, 0, 0, 0, 9, 0, 1, 0));
      tv.push_back(mk(1, 0, 0,  0, 1, 1, 0, 0, 1, 1, 0));
      tv.push_back(mk(1, 0, 0,  0, 1, 1, 1, 1, 0, 0, 0));
      tv.push_back(mk(1, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0));
      tv.push_back(mk(1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(1, 0, 0,  0, 1, 0, 0, 9, 1, 1, 0));
      tv.push_back(mk(1, 0, 0,  0, 1, 1, 0, 0, 1, 1, 0));
      tv.push_back(mk(2, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(2, 0, 1,  8, 1, 1, 0, 8, 0, 0, 0));
      tv.push_back(mk(2, 0, 0,  0, 1, 1, 0, 9, 0, 0, 0));
      tv.push_back(mk(2, 0, 0,  0, 1, 1, 0, 9, 1, 1, 0));
      tv.push_back(mk(2, 0, 0,  0, 1, 1, 0, 9, 1, 1, 0));
      tv.push_back(mk(2, 0, 0,  0, 0, 1, 1, 9, 0, 0, 0));
      tv.push_back(mk(2, 0, 0,  0, 1, 0, 0, 8, 0, 0, 0));
      tv.push_back(mk(2, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(2, 0, 0,  0, 1, 0, 0, 0, 1, 1, 0));
      tv.push_back(mk(3, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(3, 0, 1,  7, 1, 1, 0, 7, 0, 0, 0));
      tv.push_back(mk(3, 0, 0,  0, 1, 1, 0, 8, 0, 0, 0));
      tv.push_back(mk(3, 0, 0,  0, 1, 1, 0, 9, 0, 0, 0));
      tv.push_back(mk(3, 0, 0,  0, 1, 1, 0, 9, 1, 1, 1));
      tv.push_back(mk(3, 0, 0,  0, 1, 1, 0, 9, 0, 1, 1));
      tv.push_back(mk(3, 0, 0,  0, 1, 1, 0, 9, 0, 1, 1));
      tv.push_back(mk(3, 0, 0,  0, 1, 0, 0, 9, 0, 1, 1));
      tv.push_back(mk(3, 0, 1,  3, 1, 1, 0, 3, 0, 1, 0));
      tv.push_back(mk(3, 0, 0,  0, 1, 1, 0, 4, 0, 1, 0));
      tv.push_back(mk(3, 0, 0,  0, 1, 0, 0, 3, 0, 1, 0));
      tv.push_back(mk(3, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(3, 0, 1,  9, 0, 1, 0, 9, 0, 0, 0));
      tv.push_back(mk(3, 0, 0,  0, 1, 1, 0, 9, 1, 1, 1));
      tv.push_back(mk(3, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(mk(3, 0, 0,  0, 1, 0, 0, 0, 1, 1, 1));

      for (int i = 0; i < tv.size(); i++) begin
         tick(tv[i].rst, tv[i].ld, int'(tv[i].lv), tv[i].en,
              tv[i].up, tv[i].clr);
         chk_all($sformatf("v%0d", i), tv[i].sel, tv[i].q,
                 tv[i].tc, tv[i].ovf, tv[i].done);
      end

      // non-one-shot instances never raise done
      chk("d0.done_const", int'(donea[0]), 0);
      chk("d2.done_const", int'(donea[2]), 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/modulo_updown_counter.md
MODULO_UPDOWN_COUNTER -- requirements
Module: modulo_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter width in bits (range 2..32).
REQ-002 The block SHALL have parameter MODULUS, default 256, count range 0..MODULUS-1 (range 2..2^WIDTH).
REQ-003 The block SHALL have parameter MODE, default 0, where 0 = wrap, 1 = saturate and 2 = one-shot.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port enable  input  1  count-step qualifier.
REQ-007 The block SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 The block SHALL have port load  input  1  synchronous parallel load strobe.
REQ-009 The block SHALL have port load_val  input  WIDTH  value captured on load.
REQ-010 The block SHALL have port clr_ovf  input  1  clears the sticky overflow flag.
REQ-011 The block SHALL have port q  output  WIDTH  registered count value.
REQ-012 The block SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-013 The block SHALL have port ovf  output  1  registered sticky overflow/underflow flag.
REQ-014 The block SHALL have port done  output  1  registered one-shot completion flag (MODE 2 only; constant 0 otherwise).

Function
REQ-015 Priority per edge SHALL be reset > load > enable; with enable = 0 and no load, q SHALL hold.
REQ-016 On load, q SHALL take load_val; if load_val >= MODULUS, q SHALL take MODULUS-1.
REQ-017 On load, done SHALL clear and no tc SHALL be generated; ovf SHALL be unaffected.
REQ-018 An enabled step SHALL change q by +1 (up = 1) or -1 (up = 0), computed in WIDTH bits.
REQ-019 A terminal step SHALL be an enabled step from q = MODULUS-1 with up = 1, or from q = 0 with up = 0.
REQ-020 For a terminal step in MODE 0, q SHALL become 0 (up) or MODULUS-1 (down).
REQ-021 For a terminal step in MODE 1, q SHALL hold at its current value.
REQ-022 MODE 2 SHALL use a two-state FSM, RUN and DONE, with RUN as the reset state.
REQ-023 In MODE 2, a terminal step in RUN SHALL hold q, move the FSM to DONE and set done = 1.
REQ-024 In MODE 2, enable SHALL be ignored in DONE; only load or reset SHALL return the FSM to RUN.
REQ-025 On every terminal step, tc SHALL be 1 in the following cycle only, and 0 otherwise.
REQ-026 In MODE 1, repeated terminal steps SHALL each pulse tc; in MODE 2, enables in DONE SHALL produce no tc.
REQ-027 On every terminal step, ovf SHALL set to 1 and remain set until clr_ovf or reset.
REQ-028 clr_ovf SHALL clear ovf on the next edge; if a terminal step occurs in the same cycle, set SHALL win.
REQ-029 A change of up SHALL take effect on the same edge it is sampled, with no extra latency.
REQ-030 Changing up between steps SHALL be legal and glitch-free; terminal detection SHALL use the current up.
REQ-031 Counting latency SHALL be one cycle from enable sampled high to the updated q.

Reset
REQ-032 When reset is sampled high, q = 0, tc = 0, ovf = 0, done = 0 and FSM = RUN SHALL hold on the following edge.
REQ-033 Reset SHALL override load, enable and clr_ovf in the same cycle.
REQ-034 Reset asserted mid-count or in DONE SHALL abort operation with no tc pulse.
REQ-035 Outputs SHALL be undefined only before the first reset edge.

Verification
REQ-036 Default parameters, reset, then enable = 1, up = 1 for 256 cycles -> q runs 0..255 then 0; tc is high for one cycle after q = 255; ovf = 1.
REQ-037 MODULUS = 10, MODE 0, reset, up = 0, enable = 1 -> q goes 0 to 9, 8, ...; tc pulses after the 0-to-9 step.
REQ-038 MODULUS = 10, MODE 1, load_val = 8, up = 1, enable for 4 cycles -> q = 9, 9, 9; tc pulses twice; ovf = 1; then clr_ovf -> ovf = 0.
REQ-039 MODULUS = 10, MODE 2, load_val = 7, up = 1, enable continuously -> q = 8, 9, then holds 9 with done = 1 and a single tc; load_val = 3 -> q = 3, done = 0.
REQ-040 Default parameters: load = 1 together with enable = 1, load_val = 200 -> q = 200; reset with load in the same cycle -> q = 0; clr_ovf during a terminal step -> ovf stays 1.
REQ-041 MODULUS = 10, load_val = 15 -> q = 9 (clamped to MODULUS-1).
